inst_split_issue: RTL and testbench
===================================

// Module: inst_split_issue
// PURPOSE
//   Issue sequencer between fetch and decode that expands split stores.
//   A fetched sb/sh is issued as two words: the prefix word from InstDivider, then the original store.
//   Every other instruction passes through one buffer stage unchanged.
//   The prefix carries out_is_prefix=1. Decode treats it as lw to x0 at the same address.
//   The prefix keeps the store opcode field, so decode must not decode it by opcode alone.
// PARAMETERS
//   WIDTH_INST  32  instruction width (`WIDTH_INST)
//   WIDTH_PC    32  program-counter width
// PORTS
//   clk            in   1           clock, rising edge
//   rst_n          in   1           reset: asynchronous assert, active-low
//   flush          in   1           synchronous pipeline flush (branch/exception)
//   in_valid       in   1           fetch presents an instruction
//   in_ready       out  1           sequencer accepts in_inst this cycle
//   in_inst        in   WIDTH_INST  fetched instruction
//   in_pc          in   WIDTH_PC    PC of in_inst
//   out_valid      out  1           word presented to decode
//   out_ready      in   1           decode accepts out_inst this cycle
//   out_inst       out  WIDTH_INST  issued instruction word
//   out_pc         out  WIDTH_PC    PC; the same PC for both halves of a split
//   out_is_prefix  out  1           1 = out_inst is the lw prefix of a split store
// BEHAVIOUR
//   Reset: state=EMPTY; out_valid, out_is_prefix, in_ready all 0; out_inst, out_pc =0.
//   Split detect: opcode==7'b0100011 && funct3[2:1]==2'b00 (sb 000, sh 001).
//     sw and all other opcodes are not split.
//   Registers: one holding register {inst, pc} plus state. Output drives straight from registers.
//   FSM states:
//     EMPTY  out_valid=0.
//     HOLD   plain instruction presented. out_is_prefix=0.
//     PRE    divider(held inst) presented. out_is_prefix=1.
//     POST   held store presented unchanged. out_is_prefix=0.
//   Transitions on a load (in_valid & in_ready), taken from EMPTY, HOLD or POST:
//     split instruction -> PRE; otherwise -> HOLD.
//   Transitions with no load:
//     PRE + out fire -> POST.
//     HOLD/POST + out fire -> EMPTY.
//     No fire -> stay (out_* held stable; AXI-style, no retraction).
//   in_ready = !flush && (state==EMPTY || ((state==HOLD||state==POST) && out_ready)).
//     in_ready is never 1 in PRE, so a split costs exactly one fetch bubble.
//   Latency: 1 cycle from in fire to out_valid. Throughput: 1/cycle for plain, 2 cycles per sb/sh.
//   flush has priority over everything:
//     next state = EMPTY and out_valid=0 next cycle.
//     An out fire in the flush cycle still counts.
//     No input is accepted in the flush cycle.
//     A flush while in PRE or POST drops both halves (no orphan store issued).
//   Reset asserted mid-split drops the split; no half is replayed after reset.
//   PC is never incremented here; fetch owns PC advance.
// STRUCTURE
//   Shared package/param.v: state encoding (2 bits).
//     Also there: OPC_STORE=7'b0100011 and F3_SB/F3_SH.
//   One sub-module: InstDivider (combinational), fed by the holding register.
//   Output mux selects InstDivider output when state==PRE.
//   Target size: about 150 lines.
// TESTING
//   1. addi x1,x0,1 (0x00100093), pc=0x100, out_ready=1.
//      -> next cycle out_inst=0x00100093, out_pc=0x100, prefix=0.
//   2. sb x5,3(x2) (0x005101A3), pc=0x104, out_ready=1.
//      -> cycle1: out_inst=0x00312023, prefix=1, in_ready=0.
//      -> cycle2: out_inst=0x005101A3, prefix=0. Both halves have out_pc=0x104.
//   3. Back-to-back stream addi, sh, sw, addi with out_ready=1.
//      -> 5 output words, order addi, prefix, sh, sw, addi. Exactly one in_ready=0 cycle.
//   4. out_ready=0 for 3 cycles while in PRE.
//      -> out_inst/out_pc/prefix stable, in_ready=0. The store follows the cycle after out_ready=1.
//   5. flush asserted in POST with in_valid=1.
//      -> next cycle out_valid=0, store not issued, input not consumed (in_ready=0).
//   6. rst_n pulsed low asynchronously in PRE.
//      -> out_valid=0 immediately. After release, state EMPTY and in_ready=1 on the first clock.

Source files
------------

// File: rtl/inst_split_issue_pkg.sv
// inst_split_issue_pkg: shared widths, state encoding and store-split opcode constants
package inst_split_issue_pkg;

    localparam int WIDTH_INST = 32;
    localparam int WIDTH_PC   = 32;

    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_LW     = 3'b010;

    typedef enum logic [1:0] {EMPTY, HOLD, PRE, POST} state_t;

    function automatic logic is_split(input logic [31:0] inst);
        return inst[6:0] == OPC_STORE && (inst[14:12] == F3_SB || inst[14:12] == F3_SH);
    endfunction

endpackage

// File: rtl/inst_split_issue_divider.sv
// inst_split_issue_divider: builds the lw-to-x0 prefix word of a split store
// The store opcode is kept, so decode identifies the prefix by out_is_prefix rather than by opcode.
module inst_split_issue_divider
    import inst_split_issue_pkg::*;
#(
    parameter int WIDTH_INST = inst_split_issue_pkg::WIDTH_INST
) (
    input  logic [WIDTH_INST-1:0] inst,
    output logic [WIDTH_INST-1:0] prefix
);

    // I-type layout: the store's split immediate is rejoined into imm[11:0], rd = x0
    assign prefix = WIDTH_INST'({inst[31:25], inst[11:7], inst[19:15], F3_LW, 5'b00000, OPC_STORE});

endmodule

// File: rtl/inst_split_issue.sv
// inst_split_issue: fetch-to-decode issue stage that expands sb/sh into a prefix word plus the store
module inst_split_issue
    import inst_split_issue_pkg::*;
#(
    parameter int WIDTH_INST = inst_split_issue_pkg::WIDTH_INST,
    parameter int WIDTH_PC   = inst_split_issue_pkg::WIDTH_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH_INST-1:0] in_inst,
    input  logic [WIDTH_PC-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_INST-1:0] out_inst,
    output logic [WIDTH_PC-1:0]   out_pc,
    output logic                  out_is_prefix
);

    state_t                state, state_n;
    logic [WIDTH_INST-1:0] hold_inst, div_inst;
    logic [WIDTH_PC-1:0]   hold_pc;
    logic                  load, out_fire;

    inst_split_issue_divider #(.WIDTH_INST(WIDTH_INST)) u_div (
        .inst   (hold_inst),
        .prefix (div_inst)
    );

    // rst_n gating keeps in_ready low while reset is held
    assign in_ready      = rst_n && !flush && (state == EMPTY || ((state == HOLD || state == POST) && out_ready));
    assign load          = in_valid && in_ready;
    assign out_valid     = state != EMPTY;
    assign out_fire      = out_valid && out_ready;
    assign out_is_prefix = state == PRE;
    assign out_inst      = out_is_prefix ? div_inst : hold_inst;
    assign out_pc        = hold_pc;

    always_comb begin
        state_n = state;
        if (flush)
            state_n = EMPTY;
        else if (load)
            state_n = is_split(in_inst[31:0]) ? PRE : HOLD;
        else if (out_fire)
            state_n = state == PRE ? POST : EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            hold_inst <= '0;
            hold_pc   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                hold_inst <= in_inst;
                hold_pc   <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_inst_split_issue.sv
// tb_inst_split_issue: randomized check of inst_split_issue against a queue-of-words reference model
module tb_inst_split_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_prefix;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pre;
    } word_t;

    word_t q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    inst_split_issue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_is_prefix (out_is_prefix)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic split(input logic [31:0] i);
        return i[6:0] == 7'h23 && i[14:13] == 2'b00;
    endfunction

    function automatic logic [31:0] prefix_of(input logic [31:0] i);
        return {i[31:25], i[11:7], i[19:15], 3'b010, 5'b00000, 7'h23};
    endfunction

    // Checks the current cycle against the pending-word queue, then advances one clock
    task automatic step();
        logic exp_rdy, fire, acc;
        #1;
        exp_rdy = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("out_inst", out_inst, q[0].inst);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_is_prefix", out_is_prefix, q[0].pre);
        end
        fire = q.size() > 0 && out_ready;
        acc  = in_valid && exp_rdy;
        @(posedge clk);
        #1;
        if (fire) void'(q.pop_front());
        if (flush) q.delete();
        if (acc) begin
            if (split(in_inst)) q.push_back('{prefix_of(in_inst), in_pc, 1'b1});
            q.push_back('{in_inst, in_pc, 1'b0});
        end
    endtask

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_prefix", out_is_prefix, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h100;
        step();
        in_inst = 32'h005101A3;
        in_pc   = 32'h104;
        step();
        in_valid = 1'b0;
        #1;
        chk("sb_prefix_inst", out_inst, 32'h00312023);
        chk("sb_prefix_flag", out_is_prefix, 1);
        chk("sb_prefix_pc", out_pc, 32'h104);
        chk("sb_prefix_in_ready", in_ready, 0);
        step();
        #1;
        chk("sb_store_inst", out_inst, 32'h005101A3);
        chk("sb_store_flag", out_is_prefix, 0);
        chk("sb_store_pc", out_pc, 32'h104);
        step();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_inst   = 32'h00511223;
        in_pc     = 32'h200;
        step();
        in_valid = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 0);
        q.delete();
        #1;
        rst_n = 1'b1;
        step();
        step();
        repeat (3000) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom % 2 == 0) begin
                r[6:0]   = 7'h23;
                r[14:12] = 3'($urandom % 4);
            end
            in_inst   = r;
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_valid  = $urandom % 4 != 0;
            out_ready = $urandom % 4 != 0;
            flush     = $urandom % 20 == 0;
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
